// File: rtl/gt_link_supervisor.sv
// rtl/gt_link_supervisor.sv - GT channel bring-up supervisor: status sync, reset pulsing, retry budget
// Pulses gt_rst_out, waits for all channels to be stably good, retries on timeout, latches fail.
module gt_link_supervisor #(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY      = 7
) (
  input  logic            init_clk,
  input  logic            rst,
  input  logic [N_CH-1:0] tx_good_in,
  input  logic [N_CH-1:0] rx_good_in,
  output logic            gt_rst_out,
  output logic [N_CH-1:0] tx_good_init_synced,
  output logic [N_CH-1:0] rx_good_init_synced,
  output logic            link_up,
  output logic            fail,
  output logic [7:0]      retry_cnt
);

  localparam int W  = 2 * N_CH;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT,
    S_UP,
    S_FAIL
  } state_t;

  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0][W-1:0]  sync_q, sync_d;
  logic [RW-1:0]                  rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]                  stable_q, stable_d;
  logic [TW-1:0]                  timeout_q, timeout_d;
  logic [7:0]                     retry_q, retry_d;
  logic                           gt_rst_q, gt_rst_d;
  logic                           link_up_q, link_up_d;
  logic                           fail_q, fail_d;

  logic                           all_good;
  logic [SW-1:0]                  stable_nxt;
  logic [TW-1:0]                  timeout_nxt;
  logic [7:0]                     retry_inc;

  // Stage 0 captures the raw inputs; the last stage is the synchronized view.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_good_in, tx_good_in};

  assign tx_good_init_synced = sync_q[SYNC_STAGES-1][N_CH-1:0];
  assign rx_good_init_synced = sync_q[SYNC_STAGES-1][W-1:N_CH];
  assign all_good            = &sync_q[SYNC_STAGES-1];

  assign gt_rst_out = gt_rst_q;
  assign link_up    = link_up_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

  always_comb begin
    stable_nxt = '0;
    if (all_good) begin
      stable_nxt = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
    end
    timeout_nxt = (timeout_q == TIMEOUT_MAX) ? timeout_q : timeout_q + TW'(1);
    retry_inc   = retry_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;
    retry_d   = retry_q;
    gt_rst_d  = gt_rst_q;
    link_up_d = 1'b0;
    fail_d    = fail_q;

    case (state_q)
      S_RESET: begin
        stable_d  = '0;
        timeout_d = '0;
        gt_rst_d  = 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_WAIT;
          rst_cnt_d = '0;
          gt_rst_d  = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      S_WAIT: begin
        stable_d  = stable_nxt;
        timeout_d = timeout_nxt;
        gt_rst_d  = 1'b0;
        // Link-up wins over a timeout landing on the same cycle.
        if (stable_nxt == STABLE_MAX) begin
          state_d = S_UP;
          retry_d = 8'd0;
        end else if (timeout_nxt == TIMEOUT_MAX) begin
          if (retry_inc == RETRY_LIMIT) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d   = S_RESET;
            retry_d   = retry_inc;
            gt_rst_d  = 1'b1;
            stable_d  = '0;
            timeout_d = '0;
          end
        end
      end

      S_UP: begin
        stable_d = stable_nxt;
        if (!all_good) begin
          state_d   = S_RESET;
          gt_rst_d  = 1'b1;
          stable_d  = '0;
          timeout_d = '0;
        end else begin
          link_up_d = 1'b1;
        end
      end

      S_FAIL: begin
        gt_rst_d = 1'b0;
        fail_d   = 1'b1;
      end

      default: begin
        state_d   = S_RESET;
        rst_cnt_d = '0;
        gt_rst_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      sync_q    <= '0;
      rst_cnt_q <= '0;
      stable_q  <= '0;
      timeout_q <= '0;
      retry_q   <= 8'd0;
      gt_rst_q  <= 1'b1;
      link_up_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rst_cnt_q <= rst_cnt_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      retry_q   <= retry_d;
      gt_rst_q  <= gt_rst_d;
      link_up_q <= link_up_d;
      fail_q    <= fail_d;
    end
  end

endmodule

// File: tb/tb_gt_link_supervisor.sv
// tb/tb_gt_link_supervisor.sv - scoreboard bench for gt_link_supervisor
// Directed steps push timed expectations; a negedge monitor pops and checks them.
module tb_gt_link_supervisor;

  localparam int N_CH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] tx_good_in = '0;
  logic [N_CH-1:0] rx_good_in = '0;
  logic            gt_rst_out;
  logic [N_CH-1:0] tx_good_init_synced;
  logic [N_CH-1:0] rx_good_init_synced;
  logic            link_up;
  logic            fail;
  logic [7:0]      retry_cnt;

  gt_link_supervisor #(
    .N_CH           (N_CH),
    .SYNC_STAGES    (2),
    .RST_CYCLES     (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (64),
    .MAX_RETRY      (2)
  ) dut (
    .init_clk            (clk),
    .rst                 (rst),
    .tx_good_in          (tx_good_in),
    .rx_good_in          (rx_good_in),
    .gt_rst_out          (gt_rst_out),
    .tx_good_init_synced (tx_good_init_synced),
    .rx_good_init_synced (rx_good_init_synced),
    .link_up             (link_up),
    .fail                (fail),
    .retry_cnt           (retry_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    bit         is_sync;
    logic       gt;
    logic       lu;
    logic       fl;
    logic [7:0] rc;
    logic [1:0] tx;
    logic [1:0] rx;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   mi;
  int   checks = 0;
  int   errors = 0;

  task automatic push_ctl(input int at, input string tag, input logic gt, input logic lu,
                          input logic fl, input logic [7:0] rc);
    exp_t e;
    e.at = at; e.tag = tag; e.is_sync = 1'b0;
    e.gt = gt; e.lu = lu; e.fl = fl; e.rc = rc;
    e.tx = '0; e.rx = '0;
    sb.push_back(e);
  endtask

  task automatic push_sync(input int at, input string tag, input logic [1:0] tx, input logic [1:0] rx);
    exp_t e;
    e.at = at; e.tag = tag; e.is_sync = 1'b1;
    e.gt = 1'b0; e.lu = 1'b0; e.fl = 1'b0; e.rc = 8'd0;
    e.tx = tx; e.rx = rx;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].at > cyc) begin
        mi++;
      end else begin
        me = sb[mi];
        sb.delete(mi);
        checks++;
        if (me.at < cyc) begin
          errors++;
          $error("FAIL %s: observed at cycle %0d, required at cycle %0d", me.tag, cyc, me.at);
        end else if (me.is_sync) begin
          assert ({tx_good_init_synced, rx_good_init_synced} === {me.tx, me.rx}) else begin
            errors++;
            $error("FAIL %s: observed tx=%b rx=%b expected tx=%b rx=%b",
                   me.tag, tx_good_init_synced, rx_good_init_synced, me.tx, me.rx);
          end
        end else begin
          assert ({gt_rst_out, link_up, fail, retry_cnt} === {me.gt, me.lu, me.fl, me.rc}) else begin
            errors++;
            $error("FAIL %s: observed gt=%b lu=%b fail=%b retry=%0d expected gt=%b lu=%b fail=%b retry=%0d",
                   me.tag, gt_rst_out, link_up, fail, retry_cnt, me.gt, me.lu, me.fl, me.rc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int r0;

    // Power-on reset with inputs already good.
    rst = 1'b1; tx_good_in = 2'b11; rx_good_in = 2'b11;
    @(negedge clk);
    b = cyc;
    push_ctl (b + 1, "por_state", 1'b1, 1'b0, 1'b0, 8'd0);
    push_sync(b + 1, "por_sync", 2'b00, 2'b00);
    wait_until(b + 2);

    // Bring-up with all channels good from the start.
    rst = 1'b0; b = cyc;
    push_sync(b + 1,  "lag_1",    2'b00, 2'b00);
    push_sync(b + 2,  "lag_2",    2'b11, 2'b11);
    push_ctl (b + 3,  "rst_hold", 1'b1, 1'b0, 1'b0, 8'd0);
    push_ctl (b + 4,  "rst_done", 1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl (b + 12, "up_pre",   1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl (b + 13, "up_first", 1'b0, 1'b1, 1'b0, 8'd0);
    wait_until(b + 14);

    // One-cycle rx_good_in[1] glitch while up.
    b = cyc; rx_good_in[1] = 1'b0;
    push_ctl (b + 2,  "drop_seen",  1'b0, 1'b1, 1'b0, 8'd0);
    push_sync(b + 2,  "drop_sync",  2'b11, 2'b01);
    push_ctl (b + 3,  "link_fall",  1'b1, 1'b0, 1'b0, 8'd0);
    push_sync(b + 3,  "drop_back",  2'b11, 2'b11);
    push_ctl (b + 6,  "rerst_hold", 1'b1, 1'b0, 1'b0, 8'd0);
    push_ctl (b + 7,  "rerst_done", 1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl (b + 15, "relink_pre", 1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl (b + 16, "relink",     1'b0, 1'b1, 1'b0, 8'd0);
    wait_until(b + 1);
    rx_good_in[1] = 1'b1;
    wait_until(b + 17);

    // rx_good_in[0] toggling every 5 cycles, then a link-up on the last WAIT cycle.
    b = cyc; rx_good_in = 2'b10;
    push_ctl(b + 2,   "tog_seen",   1'b0, 1'b1, 1'b0, 8'd0);
    push_ctl(b + 3,   "tog_rst",    1'b1, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 7,   "tog_wait",   1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 70,  "tog_pre_to", 1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 71,  "tog_retry",  1'b1, 1'b0, 1'b0, 8'd1);
    push_ctl(b + 138, "late_pre",   1'b0, 1'b0, 1'b0, 8'd1);
    push_ctl(b + 139, "late_up",    1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 140, "late_link",  1'b0, 1'b1, 1'b0, 8'd0);
    for (int k = 5; k <= 80; k += 5) begin
      wait_until(b + k);
      rx_good_in[0] = ~rx_good_in[0];
    end
    wait_until(b + 129);
    rx_good_in[0] = 1'b1;
    wait_until(b + 141);

    // Mid-operation reset, then inputs held low until the retry budget is spent.
    r0 = cyc; rst = 1'b1; tx_good_in = 2'b00; rx_good_in = 2'b00;
    #1;
    checks++;
    assert ({gt_rst_out, link_up, retry_cnt} === {1'b1, 1'b0, 8'd0}) else begin
      errors++;
      $error("FAIL rst_async: observed gt=%b lu=%b retry=%0d expected gt=1 lu=0 retry=0",
             gt_rst_out, link_up, retry_cnt);
    end
    wait_until(r0 + 2);
    rst = 1'b0; b = cyc;
    push_ctl(b + 3,   "to_rst_hold", 1'b1, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 4,   "to_wait",     1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 67,  "to_pre",      1'b0, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 68,  "to_retry",    1'b1, 1'b0, 1'b0, 8'd1);
    push_ctl(b + 71,  "to_rst2",     1'b1, 1'b0, 1'b0, 8'd1);
    push_ctl(b + 72,  "to_wait2",    1'b0, 1'b0, 1'b0, 8'd1);
    push_ctl(b + 135, "fail_pre",    1'b0, 1'b0, 1'b0, 8'd1);
    push_ctl(b + 136, "fail_set",    1'b0, 1'b0, 1'b1, 8'd1);
    push_ctl(b + 150, "fail_hold",   1'b0, 1'b0, 1'b1, 8'd1);
    wait_until(b + 151);

    // Reset out of FAIL.
    r0 = cyc; rst = 1'b1;
    #1;
    checks++;
    assert ({fail, retry_cnt, gt_rst_out, link_up} === {1'b0, 8'd0, 1'b1, 1'b0}) else begin
      errors++;
      $error("FAIL fail_clear: observed fail=%b retry=%0d gt=%b lu=%b expected fail=0 retry=0 gt=1 lu=0",
             fail, retry_cnt, gt_rst_out, link_up);
    end
    wait_until(r0 + 2);
    rst = 1'b0; b = cyc;
    push_ctl(b + 1, "post_fail_rst1", 1'b1, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 3, "post_fail_rst3", 1'b1, 1'b0, 1'b0, 8'd0);
    push_ctl(b + 4, "post_fail_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    wait_until(b + 6);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d pending expectations, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gt_link_supervisor.md
GT_LINK_SUPERVISOR -- requirements
Module: gt_link_supervisor

Interface
REQ-001 Parameter N_CH, default 4: number of GT channels supervised (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per status bit (2..4).
REQ-003 Parameter RST_CYCLES, default 16: gt_rst_out assertion length per reset attempt (>=1).
REQ-004 Parameter STABLE_CYCLES, default 256: consecutive all-good cycles required for link-up (>=1).
REQ-005 Parameter TIMEOUT_CYCLES, default 65536: wait budget per attempt after reset release (> STABLE_CYCLES).
REQ-006 Parameter MAX_RETRY, default 7: failed attempts tolerated before FAIL (1..255).
REQ-007 init_clk  in  1  sole clock; all logic in this domain.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 tx_good_in  in  N_CH  per-channel TX-ready status, asynchronous to init_clk.
REQ-010 rx_good_in  in  N_CH  per-channel RX-ready status, asynchronous to init_clk.
REQ-011 gt_rst_out  out  1  reset request to all GT channels, active-high.
REQ-012 tx_good_init_synced  out  N_CH  synchronized tx_good_in.
REQ-013 rx_good_init_synced  out  N_CH  synchronized rx_good_in.
REQ-014 link_up  out  1  all channels good and stable.
REQ-015 fail  out  1  retry budget exhausted; sticky.
REQ-016 retry_cnt  out  8  failed attempts in current bring-up.

Function
REQ-017 Each tx/rx status bit SHALL pass through a SYNC_STAGES-deep flop chain; synced outputs lag inputs by exactly SYNC_STAGES init_clk edges.
REQ-018 all_good SHALL be the AND of every tx_good_init_synced and rx_good_init_synced bit.
REQ-019 Stable counter SHALL increment while all_good=1, clear to 0 on any cycle all_good=0, and saturate at STABLE_CYCLES.
REQ-020 FSM states SHALL be RESET, WAIT, UP, FAIL.
REQ-021 RESET: gt_rst_out=1 for exactly RST_CYCLES cycles, stable and timeout counters held at 0, then -> WAIT.
REQ-022 WAIT: gt_rst_out=0; timeout counter increments each cycle.
REQ-023 WAIT -> UP when stable counter reaches STABLE_CYCLES; retry_cnt cleared on entry to UP.
REQ-024 WAIT, timeout counter reaches TIMEOUT_CYCLES without link-up: if retry_cnt+1 = MAX_RETRY -> FAIL, else retry_cnt+1 and -> RESET.
REQ-025 Stable-reached and timeout in the same cycle SHALL resolve to UP.
REQ-026 UP: link_up=1 (registered, asserted the cycle after entry); any all_good=0 cycle -> RESET with retry_cnt unchanged (0) and link_up deasserted the following cycle.
REQ-027 FAIL: gt_rst_out=0, fail=1, link_up=0; exit only via rst.
REQ-028 Counter widths SHALL be sized from their parameters; no wrap-around permitted.
REQ-029 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-030 Asserting rst SHALL immediately clear sync flops, counters, retry_cnt, link_up, fail, and set state RESET with gt_rst_out=1.
REQ-031 After rst deasserts, RESET SHALL run its full RST_CYCLES count from 0.
REQ-032 rst mid-operation (any state, including FAIL) SHALL behave identically to power-on reset.

Verification (N_CH=2, SYNC_STAGES=2, RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=64, MAX_RETRY=2)
REQ-033 Release rst, all good inputs high from start -> gt_rst_out high 4 cycles, link_up=1 after 2 sync + 8 stable cycles + 1, retry_cnt=0.
REQ-034 Good inputs held low -> gt_rst_out pulses 4 cycles, retry_cnt=1 after 64 WAIT cycles, second timeout -> fail=1, gt_rst_out=0, retry_cnt=1 held.
REQ-035 In UP, drop rx_good_in[1] for 1 cycle -> link_up falls 2 sync cycles + 1 later, gt_rst_out=1 for 4 cycles, relinks after 8 stable cycles.
REQ-036 rx_good_in[0] toggling every 5 cycles in WAIT -> stable counter never reaches 8, timeout retry occurs at cycle 64.
REQ-037 All good inputs rise so stable count hits 8 on WAIT cycle 64 -> UP, no retry increment.
REQ-038 Assert rst while in FAIL -> fail=0, retry_cnt=0, gt_rst_out=1 immediately, new 4-cycle reset after release.
